// File: rtl/fifo_drain_reader_if.sv
// fifo_drain_reader_if: FIFO read-side and output stream signals of the drain reader
// Ports (master = reader):
//   fifo_dout, fifo_empty, fifo_count : from the FIFO into the reader
//   fifo_read                         : pop request from the reader to the FIFO
//   m_data, m_valid                   : stream from the reader to downstream
//   m_ready                           : downstream accept into the reader
interface fifo_drain_reader_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_read;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  modport master (
    input  fifo_dout, fifo_empty, fifo_count, m_ready,
    output fifo_read, m_data, m_valid
  );
  modport slave (
    output fifo_dout, fifo_empty, fifo_count, m_ready,
    input  fifo_read, m_data, m_valid
  );
endinterface

// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: drains an 8-bit sync FIFO in bursts onto a valid/ready stream
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : fifo_drain_reader_if.master (FIFO read side + output stream)
//   busy      : high while waiting for a burst or draining
//   words_out : stream transfers completed, wraps at 16 bits
module fifo_drain_reader #(
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 4,
  parameter int BURST_THRESH = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_drain_reader_if.master   bus,
  output logic                  busy,
  output logic [15:0]           words_out
);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t            state, state_nxt;
  logic [7:0]        timer;
  logic              inflight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] buf0, buf1;
  logic              pop;
  logic [1:0]        wr_idx;
  logic [2:0]        avail;
  assign bus.m_valid = occ != 2'd0;
  assign bus.m_data  = buf0;
  assign pop         = bus.m_valid & bus.m_ready;
  // slot the returning word lands in, after this cycle's pop has shifted the buffer
  assign wr_idx      = occ - {1'b0, pop};
  // buffer space already committed: held words plus the pending capture, minus what leaves now
  assign avail       = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.fifo_empty ? IDLE : WAIT;
      WAIT:    state_nxt = (bus.fifo_count >= CNT_W'(BURST_THRESH) || timer == 8'(TIMEOUT - 1)) ? DRAIN :
                           bus.fifo_empty ? IDLE : WAIT;
      DRAIN:   state_nxt = (bus.fifo_empty && !inflight && occ == 2'd0) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy          = state != IDLE;
    bus.fifo_read = state == DRAIN && !bus.fifo_empty && avail < 3'd2;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      timer     <= '0;
      inflight  <= 1'b0;
      occ       <= '0;
      buf0      <= '0;
      buf1      <= '0;
      words_out <= '0;
    end else begin
      timer    <= state == IDLE ? 8'd0 : state == WAIT ? timer + 8'd1 : timer;
      inflight <= bus.fifo_read;
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      if (pop && occ == 2'd2) buf0 <= buf1;
      else if (inflight && wr_idx == 2'd0) buf0 <= bus.fifo_dout;
      if (inflight && wr_idx == 2'd1) buf1 <= bus.fifo_dout;
      if (pop) words_out <= words_out + 16'd1;
    end
endmodule

// File: tb/tb_fifo_drain_reader.sv
// tb_fifo_drain_reader: directed bench for fifo_drain_reader with a behavioural 8-deep FIFO
module tb_fifo_drain_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] words_out;
  int          vectors = 0;
  int          miscompares = 0;
  int          rd_empty_err = 0;
  int          stab_err = 0;
  int          rd_cnt = 0;
  logic [7:0]  rx[$];
  fifo_drain_reader_if #(.DATA_W(8), .CNT_W(4)) bus ();
  fifo_drain_reader #(.DATA_W(8), .CNT_W(4), .BURST_THRESH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .words_out(words_out)
  );
  always #5 clk = ~clk;
  logic [7:0] mem[8];
  logic [2:0] rp = 3'd0, wp = 3'd0;
  logic [3:0] cnt = 4'd0;
  int         ld_n = 0;
  logic [7:0] ld_first = 8'd0, ld_step = 8'd0;
  logic       clr = 1'b0;
  initial bus.fifo_dout = 8'd0;
  assign bus.fifo_empty = cnt == 4'd0;
  assign bus.fifo_count = cnt;
  always @(posedge clk) begin
    if (clr) begin
      rp  <= 3'd0;
      wp  <= 3'd0;
      cnt <= 4'd0;
    end else begin
      if (bus.fifo_read) begin
        if (cnt == 4'd0) rd_empty_err <= rd_empty_err + 1;
        else begin
          bus.fifo_dout <= mem[rp];
          rp <= rp + 3'd1;
        end
      end
      for (int i = 0; i < ld_n; i++) mem[3'(wp + 3'(i))] <= 8'(ld_first + ld_step * 8'(i));
      wp  <= wp + 3'(ld_n);
      cnt <= cnt + 4'(ld_n) - ((bus.fifo_read && cnt != 4'd0) ? 4'd1 : 4'd0);
    end
  end
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'd0;
  always @(negedge clk) begin
    if (rst && pv && !pr && (!bus.m_valid || bus.m_data !== pd)) stab_err++;
    if (bus.fifo_read) rd_cnt++;
    if (rst && bus.m_valid && bus.m_ready) rx.push_back(bus.m_data);
    pv = rst && bus.m_valid;
    pr = bus.m_ready;
    pd = bus.m_data;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] first, input logic [7:0] step, input int n);
    ld_first = first;
    ld_step  = step;
    ld_n     = n;
    tick();
    ld_n = 0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask
  task automatic chk_rx(input string tag, input int base, input logic [7:0] first, input logic [7:0] step, input int n);
    chk({tag, "_len"}, 32'(rx.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      if (base + i < rx.size()) chk(tag, 32'(rx[base + i]), 32'(8'(first + step * 8'(i))));
  endtask
  initial begin
    int         base, rd0, nw;
    logic       any_rd;
    logic [15:0] prev;
    logic [15:0] wq[3];
    rst = 1'b0;
    bus.m_ready = 1'b0;
    clr = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(bus.fifo_read), 32'd0);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_words", 32'(words_out), 32'd0);
    tick();
    tick();
    clr = 1'b0;
    rst = 1'b1;
    tick();
    bus.m_ready = 1'b1;
    base = rx.size();
    load(8'h11, 8'h11, 4);
    chk("thr_idle", 32'(busy), 32'd0);
    tick();
    chk("thr_wait_busy", 32'(busy), 32'd1);
    chk("thr_wait_noread", 32'(bus.fifo_read), 32'd0);
    tick();
    chk("thr_rd0", 32'(bus.fifo_read), 32'd1);
    tick();
    chk("thr_rd1", 32'(bus.fifo_read), 32'd1);
    tick();
    chk("thr_rd2", 32'(bus.fifo_read), 32'd1);
    chk("thr_d2", 32'(bus.m_data), 32'h11);
    tick();
    chk("thr_rd3", 32'(bus.fifo_read), 32'd1);
    chk("thr_d3", 32'(bus.m_data), 32'h22);
    tick();
    chk("thr_rd4", 32'(bus.fifo_read), 32'd0);
    chk("thr_d4", 32'(bus.m_data), 32'h33);
    tick();
    chk("thr_d5", 32'(bus.m_data), 32'h44);
    chk("thr_v5", 32'(bus.m_valid), 32'd1);
    tick();
    chk("thr_v6", 32'(bus.m_valid), 32'd0);
    chk("thr_busy6", 32'(busy), 32'd1);
    tick();
    chk("thr_busy7", 32'(busy), 32'd0);
    chk("thr_words", 32'(words_out), 32'd4);
    chk_rx("thr_rx", base, 8'h11, 8'h11, 4);
    base = rx.size();
    load(8'hA5, 8'h00, 1);
    tick();
    chk("to_wait", 32'(busy), 32'd1);
    any_rd = 1'b0;
    for (int i = 0; i < 15; i++) begin
      any_rd |= bus.fifo_read;
      tick();
    end
    chk("to_early_read", 32'(any_rd), 32'd0);
    chk("to_read", 32'(bus.fifo_read), 32'd1);
    tick();
    tick();
    chk("to_valid", 32'(bus.m_valid), 32'd1);
    chk("to_data", 32'(bus.m_data), 32'hA5);
    wait_idle("to_idle");
    chk("to_words", 32'(words_out), 32'd5);
    chk_rx("to_rx", base, 8'hA5, 8'h00, 1);
    bus.m_ready = 1'b0;
    base = rx.size();
    load(8'h01, 8'h01, 8);
    rd0 = rd_cnt;
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("bp_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("bp_read_now", 32'(bus.fifo_read), 32'd0);
    chk("bp_count", 32'(bus.fifo_count), 32'd6);
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_data", 32'(bus.m_data), 32'h01);
    chk("bp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 80 && busy; i++) begin
      bus.m_ready = ~bus.m_ready;
      tick();
    end
    wait_idle("bp_idle");
    chk("bp_words", 32'(words_out), 32'd13);
    chk_rx("bp_rx", base, 8'h01, 8'h01, 8);
    chk("bp_empty_reads", 32'(rd_empty_err), 32'd0);
    chk("bp_stable", 32'(stab_err), 32'd0);
    bus.m_ready = 1'b1;
    base = rx.size();
    load(8'h31, 8'h01, 4);
    tick();
    tick();
    chk("rf_drain", 32'(bus.fifo_read), 32'd1);
    load(8'h35, 8'h01, 3);
    wait_idle("rf_idle");
    chk("rf_fifo_empty", 32'(bus.fifo_count), 32'd0);
    chk("rf_words", 32'(words_out), 32'd20);
    chk_rx("rf_rx", base, 8'h31, 8'h01, 7);
    force dut.words_out = 16'hFFFE;
    #1;
    release dut.words_out;
    prev = 16'hFFFE;
    nw = 0;
    load(8'h71, 8'h01, 3);
    for (int i = 0; i < 40; i++) begin
      if (words_out != prev && nw < 3) begin
        wq[nw] = words_out;
        nw++;
      end
      prev = words_out;
      tick();
    end
    chk("wr_changes", 32'(nw), 32'd3);
    if (nw == 3) begin
      chk("wr_ffff", 32'(wq[0]), 32'hFFFF);
      chk("wr_0000", 32'(wq[1]), 32'h0000);
      chk("wr_0001", 32'(wq[2]), 32'h0001);
    end
    bus.m_ready = 1'b0;
    load(8'h51, 8'h01, 4);
    for (int i = 0; i < 5; i++) tick();
    chk("mr_pre_valid", 32'(bus.m_valid), 32'd1);
    chk("mr_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_read", 32'(bus.fifo_read), 32'd0);
    chk("mr_valid", 32'(bus.m_valid), 32'd0);
    chk("mr_data", 32'(bus.m_data), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_words", 32'(words_out), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_rel_busy", 32'(busy), 32'd0);
    chk("mr_rel_words", 32'(words_out), 32'd0);
    tick();
    chk("mr_idle", 32'(busy), 32'd0);
    chk("fin_empty_reads", 32'(rd_empty_err), 32'd0);
    chk("fin_stable", 32'(stab_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
